// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU with valid/ready handshake on both sides.
//
// Single-cycle operations (ADD, SUB, CMP, AND, illegal opcodes) complete at
// the accept edge. MUL is an iterative shift-add multiplier that needs WIDTH
// cycles. The result stays held until the consumer takes it.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : request present on op/A/B
//   in_ready   : block accepts a request this cycle
//   op         : 000 ADD, 001 SUB, 010 CMP, 011 AND, 100 MUL, others illegal
//   A, B       : unsigned operands, WIDTH bits
//   out_valid  : result fields valid
//   out_ready  : consumer takes the result
//   RESULT     : 2*WIDTH-bit result, zero-extended for narrow operations
//   carry      : ADD carry-out
//   borrow     : SUB borrow (A < B)
//   COMPARE    : {A>B, A==B, A<B}, one-hot for CMP, zero otherwise
//   err        : illegal opcode flag
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] RESULT,
    output logic               carry,
    output logic               borrow,
    output logic [2:0]         COMPARE,
    output logic               err
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    // Holds in_ready low until the first clock edge after reset release.
    logic              ready_en_q;

    logic              out_valid_q;
    logic [RW-1:0]     result_q;
    logic              carry_q;
    logic              borrow_q;
    logic [2:0]        compare_q;
    logic              err_q;

    // Shift-add multiplier working registers.
    logic [RW-1:0]     mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [RW-1:0]     prod_q;
    logic [CNT_W-1:0]  cnt_q;

    // Single-cycle operation results, computed from the live inputs.
    logic [WIDTH:0]    sum_w;
    logic [WIDTH-1:0]  diff_w;
    logic [RW-1:0]     sc_result_d;
    logic              sc_carry_d;
    logic              sc_borrow_d;
    logic [2:0]        sc_compare_d;
    logic              sc_err_d;

    logic [RW-1:0]     partial_d;
    logic              accept;

    assign in_ready = ready_en_q &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign RESULT    = result_q;
    assign carry     = carry_q;
    assign borrow    = borrow_q;
    assign COMPARE   = compare_q;
    assign err       = err_q;

    always_comb begin
        sum_w        = {1'b0, A} + {1'b0, B};
        diff_w       = A - B;
        sc_result_d  = '0;
        sc_carry_d   = 1'b0;
        sc_borrow_d  = 1'b0;
        sc_compare_d = 3'b000;
        sc_err_d     = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result_d = {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
                sc_carry_d  = sum_w[WIDTH];
            end
            OP_SUB: begin
                sc_result_d = {{WIDTH{1'b0}}, diff_w};
                sc_borrow_d = (A < B);
            end
            OP_CMP: begin
                sc_compare_d = {(A > B), (A == B), (A < B)};
            end
            OP_AND: begin
                sc_result_d = {{WIDTH{1'b0}}, (A & B)};
            end
            OP_MUL: begin
                // Handled by the iterative path; nothing to compute here.
            end
            default: begin
                sc_err_d = 1'b1;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set. The full product never exceeds RW bits.
    assign partial_d = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            compare_q   <= 3'b000;
            err_q       <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                // Accept is possible from IDLE or from DONE with out_ready,
                // so a held result is handed off on this same edge.
                if (op == OP_MUL) begin
                    state_q     <= S_BUSY;
                    out_valid_q <= 1'b0;
                    mcand_q     <= {{WIDTH{1'b0}}, A};
                    mplier_q    <= B;
                    prod_q      <= '0;
                    cnt_q       <= '0;
                end else begin
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                    result_q    <= sc_result_d;
                    carry_q     <= sc_carry_d;
                    borrow_q    <= sc_borrow_d;
                    compare_q   <= sc_compare_d;
                    err_q       <= sc_err_d;
                end
            end else begin
                case (state_q)
                    S_BUSY: begin
                        prod_q   <= partial_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                        // The last step publishes the product directly so
                        // DONE is reached exactly WIDTH edges after accept.
                        if (cnt_q == LAST_ITER) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= partial_d;
                            carry_q     <= 1'b0;
                            borrow_q    <= 1'b0;
                            compare_q   <= 3'b000;
                            err_q       <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        if (out_ready) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                    S_IDLE: begin
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq at WIDTH=4.
// A transaction-level reference model tracks what the outputs must be; a
// compare process checks every output on every falling clock edge. Directed
// sequences pin literal values, then randomized traffic exercises the rest.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] RESULT;
    logic          carry;
    logic          borrow;
    logic [2:0]    COMPARE;
    logic          err;

    int checks = 0;
    int errors = 0;
    int last_send_cycles = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RESULT    (RESULT),
        .carry     (carry),
        .borrow    (borrow),
        .COMPARE   (COMPARE),
        .err       (err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic definition of each operation.
    function automatic void ref_op(input int o, input int a, input int b,
                                   output int r, output bit c, output bit bo,
                                   output int cm, output bit er);
        int p;
        p  = 1 << W;
        r  = 0;
        c  = 1'b0;
        bo = 1'b0;
        cm = 0;
        er = 1'b0;
        case (o)
            0: begin r = (a + b) % p; c = ((a + b) >= p); end
            1: begin r = (a - b + p) % p; bo = (a < b); end
            2: cm = (a > b) ? 4 : ((a == b) ? 2 : 1);
            3: r = a & b;
            4: r = a * b;
            default: er = 1'b1;
        endcase
    endfunction

    // Reference model: "hold" means a result is waiting for the consumer,
    // "busy" means a multiply is in flight with m_cnt edges left.
    bit m_up = 0, m_hold = 0, m_busy = 0;
    int m_cnt = 0, m_res = 0, m_cm = 0, m_pres = 0;
    bit m_c = 0, m_bo = 0, m_er = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit rdy, acc, nhold, nbusy, nc, nbo, ner, c, bo, er;
        int ncnt, nres, ncm, npres, r, cm;
        if (!rst_n) begin
            m_up   <= 1'b0;
            m_hold <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_res  <= 0;
            m_cm   <= 0;
            m_pres <= 0;
            m_c    <= 1'b0;
            m_bo   <= 1'b0;
            m_er   <= 1'b0;
        end else begin
            rdy   = m_up && !m_busy && (!m_hold || out_ready);
            acc   = in_valid && rdy;
            nhold = m_hold; nbusy = m_busy; ncnt = m_cnt; npres = m_pres;
            nres  = m_res;  ncm = m_cm; nc = m_c; nbo = m_bo; ner = m_er;
            if (m_busy) begin
                ncnt = ncnt - 1;
                if (ncnt == 0) begin
                    nbusy = 1'b0; nhold = 1'b1; nres = m_pres;
                    nc = 1'b0; nbo = 1'b0; ncm = 0; ner = 1'b0;
                end
            end else if (acc) begin
                ref_op(int'(op), int'(A), int'(B), r, c, bo, cm, er);
                if (op == 3'd4) begin
                    nbusy = 1'b1; ncnt = W; nhold = 1'b0; npres = r;
                end else begin
                    nhold = 1'b1; nres = r; nc = c; nbo = bo; ncm = cm; ner = er;
                end
            end else if (m_hold && out_ready) begin
                nhold = 1'b0;
            end
            m_up   <= 1'b1;
            m_hold <= nhold;
            m_busy <= nbusy;
            m_cnt  <= ncnt;
            m_pres <= npres;
            m_res  <= nres;
            m_cm   <= ncm;
            m_c    <= nc;
            m_bo   <= nbo;
            m_er   <= ner;
        end
    end

    always @(negedge clk) begin : compare
        bit rdy;
        rdy = m_up && !m_busy && (!m_hold || out_ready);
        chk("in_ready",  in_ready,  rdy);
        chk("out_valid", out_valid, m_hold);
        chk("RESULT",    RESULT,    m_res);
        chk("carry",     carry,     m_c);
        chk("borrow",    borrow,    m_bo);
        chk("COMPARE",   COMPARE,   m_cm);
        chk("err",       err,       m_er);
    end

    // Present a request and hold it until an edge where in_ready was high.
    task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit r;
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        in_valid = 1'b1; op = o; A = a; B = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            n++;
            done = r;
        end
        in_valid = 1'b0;
        last_send_cycles = n;
        chk("send_accept", done, 1'b1);
    endtask

    initial begin : stim
        int r, cm, n;
        bit c, bo, er;
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; A = '0; B = '0; out_ready = 1'b1;

        // Pin the reference model against hand-computed values.
        ref_op(0, 6, 2, r, c, bo, cm, er);   chk("ref_add_r", r, 8);   chk("ref_add_c", c, 0);
        ref_op(0, 15, 1, r, c, bo, cm, er);  chk("ref_addc_r", r, 0);  chk("ref_addc_c", c, 1);
        ref_op(1, 2, 3, r, c, bo, cm, er);   chk("ref_sub_r", r, 15);  chk("ref_sub_b", bo, 1);
        ref_op(2, 6, 2, r, c, bo, cm, er);   chk("ref_cmp_gt", cm, 4);
        ref_op(2, 3, 3, r, c, bo, cm, er);   chk("ref_cmp_eq", cm, 2);
        ref_op(3, 6, 2, r, c, bo, cm, er);   chk("ref_and", r, 2);
        ref_op(7, 6, 2, r, c, bo, cm, er);   chk("ref_ill_e", er, 1);  chk("ref_ill_r", r, 0);
        ref_op(4, 15, 15, r, c, bo, cm, er); chk("ref_mul", r, 225);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_result", RESULT, 0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("first_edge_in_ready", in_ready, 1);

        // Single-cycle operations, each visible right after the accept edge.
        send(3'd0, 4'd6, 4'd2);
        chk("add1_v", out_valid, 1); chk("add1_r", RESULT, 8'h08); chk("add1_c", carry, 0);
        send(3'd0, 4'd15, 4'd1);
        chk("add2_r", RESULT, 8'h00); chk("add2_c", carry, 1);
        send(3'd1, 4'd2, 4'd3);
        chk("sub_r", RESULT, 8'h0F); chk("sub_b", borrow, 1);
        send(3'd2, 4'd6, 4'd2);
        chk("cmp_gt", COMPARE, 3'b100); chk("cmp_gt_r", RESULT, 0);
        send(3'd2, 4'd3, 4'd3);
        chk("cmp_eq", COMPARE, 3'b010);
        send(3'd3, 4'd6, 4'd2);
        chk("and_r", RESULT, 8'h02); chk("and_cmp", COMPARE, 3'b000);
        send(3'd7, 4'd5, 4'd9);
        chk("ill_err", err, 1); chk("ill_r", RESULT, 0);

        // Multiply: latency of exactly WIDTH edges, in_ready low meanwhile.
        send(3'd4, 4'd15, 4'd15);
        n = 0;
        while (!out_valid && n < 20) begin
            chk("mul_busy_rdy", in_ready, 0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("mul_latency", n, 4);
        chk("mul_r", RESULT, 8'hE1);
        chk("mul_err", err, 0);

        // Backpressure: result held stable while the consumer stalls.
        send(3'd0, 4'd3, 4'd4);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_r", RESULT, 8'h07); chk("bp_v", out_valid, 1); chk("bp_rdy", in_ready, 0);
        end
        in_valid = 1'b1; op = 3'd0; A = 4'd9; B = 4'd8; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_r", RESULT, 8'h01); chk("bp_next_c", carry, 1); chk("bp_next_v", out_valid, 1);

        // Back-to-back stream: one accept per cycle, results in order.
        for (int i = 0; i < 4; i++) begin
            send(3'd0, 4'(i + 1), 4'(2 * i));
            chk("stream_cycles", last_send_cycles, 1);
            chk("stream_r", RESULT, 3 * i + 1);
        end

        // Reset in the middle of a multiply discards it.
        send(3'd4, 4'd7, 4'd3);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_v", out_valid, 0); chk("mrst_r", RESULT, 0); chk("mrst_rdy", in_ready, 0);
        chk("mrst_cmp", COMPARE, 0); chk("mrst_err", err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("mrst_no_stale", out_valid, 0);
        end
        send(3'd0, 4'd5, 4'd9);
        chk("mrst_add_r", RESULT, 8'h0E); chk("mrst_add_c", carry, 0);

        // Randomized traffic, including illegal opcodes and stalls.
        repeat (600) begin
            in_valid  = 1'($urandom_range(0, 1));
            op        = 3'($urandom_range(0, 7));
            A         = 4'($urandom_range(0, 15));
            B         = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: request present on op/A/B.
REQ-005 SHALL have port in_ready, output, 1: block accepts a request this cycle.
REQ-006 SHALL have port op, input, 3: operation select.
- 000 ADD
- 001 SUB
- 010 CMP
- 011 AND
- 100 MUL
- 101-111 illegal
REQ-007 SHALL have ports A and B, each input, WIDTH: unsigned operands.
REQ-008 SHALL have port out_valid, output, 1: result fields valid.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port RESULT, output, 2*WIDTH: operation result, zero-extended where narrower.
REQ-011 SHALL have port carry, output, 1: ADD carry-out.
REQ-012 SHALL have port borrow, output, 1: SUB borrow.
REQ-013 SHALL have port COMPARE, output, 3: {A>B, A==B, A<B}, one-hot for CMP.
REQ-014 SHALL have port err, output, 1: illegal opcode flag.

Function
REQ-015 SHALL implement a 3-state FSM.
- IDLE: no work held.
- BUSY: MUL iterating.
- DONE: result held.
REQ-016 SHALL accept a request on a rising edge where in_valid && in_ready; A, B and op are captured at that edge.
REQ-017 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), giving back-to-back throughput of 1 op/cycle for single-cycle ops.
REQ-018 SHALL, for ADD/SUB/CMP/AND/illegal, go to DONE at the accept edge, with out_valid=1 from that edge (latency 1 cycle).
REQ-019 SHALL, for MUL, go to BUSY at the accept edge.
- Performs one shift-add iteration per cycle.
- Goes to DONE with out_valid=1 at accept edge + WIDTH.
REQ-020 SHALL, in DONE with out_ready=1, go to IDLE, or accept the next request directly if in_valid=1.
REQ-021 SHALL, in DONE with out_ready=0, hold RESULT, flags and out_valid stable and keep in_ready=0.
REQ-022 SHALL keep in_ready=0 and out_valid=0 in BUSY; in_valid is ignored there.
REQ-023 SHALL compute ADD as RESULT = A+B mod 2^WIDTH, with carry = bit WIDTH of the full sum.
REQ-024 SHALL compute SUB as RESULT = (A-B) mod 2^WIDTH, with borrow = (A<B).
REQ-025 SHALL compute CMP with RESULT = 0 and COMPARE one-hot per REQ-013.
REQ-026 SHALL compute AND as the bitwise A&B.
REQ-027 SHALL compute MUL as the unsigned full product, 2*WIDTH bits, with no overflow.
REQ-028 SHALL drive the following to 0 whenever the completed op does not define them:
- carry, borrow
- COMPARE for non-CMP ops
- err for legal ops
REQ-029 SHALL, for an illegal op, complete like a single-cycle op with RESULT=0, all flags 0 and err=1.
REQ-030 SHALL keep RESULT, flags and err unchanged while out_valid=0 (last value retained).

Reset
REQ-031 SHALL, while rst_n=0, immediately drive:
- state=IDLE
- out_valid=0
- in_ready=0
- RESULT=0
- carry, borrow, err = 0
- COMPARE=000
REQ-032 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts.
REQ-033 SHALL, on reset asserted mid-MUL (BUSY) or in DONE, discard the operation with no result emitted after release.

Verification
REQ-034 SHALL cover, with WIDTH=4, ADD and SUB:
- ADD A=0110 B=0010 -> RESULT=00001000, carry=0.
- ADD A=1111 B=0001 -> RESULT=0, carry=1.
- SUB A=0010 B=0011 -> RESULT=00001111, borrow=1.
- All complete 1 cycle after accept.
REQ-035 SHALL cover, with WIDTH=4, CMP, AND and an illegal op:
- CMP 0110 vs 0010 -> COMPARE=100.
- CMP 0011 vs 0011 -> COMPARE=010.
- AND 0110&0010 -> 00000010.
- op=111 -> err=1, RESULT=0.
REQ-036 SHALL cover, with WIDTH=4, MUL A=1111 B=1111:
- out_valid rises exactly 4 cycles after accept.
- RESULT=11100001.
- in_ready=0 throughout BUSY.
REQ-037 SHALL cover backpressure:
- Complete ADD with out_ready=0 for 3 cycles -> RESULT/flags stable, in_ready=0.
- Raise out_ready with in_valid=1 -> next op accepted on the same edge.
REQ-038 SHALL cover a stream of 4 back-to-back ADDs with out_ready=1 -> one result per cycle, in order.
REQ-039 SHALL cover reset mid-MUL:
- Assert rst_n=0 two cycles after MUL accept -> outputs 0 immediately.
- After release, no stale out_valid; a new ADD completes correctly.
